mwpram_init: RTL and testbench

- Parametrised successor to the team's multi-write-port RAM: WPORTS write banks plus a per-entry bank-selection (LVT) array.
- Adds a self-clearing init sequencer (reset or `clr` walks every entry to INITVAL), a `ready` handshake, and defined same-address write priority.
- Adds selectable read latency (0 or 1 cycle) and optional write-to-read bypass.
- Used for rename maps, free lists and register files that must start from a known state.

---
 rtl/mwpram_init_pkg.sv | 7 +
 rtl/mwpram_bank.sv | 39 +++
 rtl/mwpram_init.sv | 106 ++++++++++
 tb/tb_mwpram_init.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mwpram_init_pkg.sv
// mwp_pkg: shared FSM state type and select-width helper for the multi-write-port RAM
package mwp_pkg;
  typedef enum logic {INIT, RUN} state_t;
  function automatic int selwidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mwpram_bank.sv
// mwpram_bank: single-write-port RAM bank with RPORTS async reads and optional init-write mux
module mwpram_bank
  import mwp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int RPORTS = 2,
  parameter int HAS_INIT = 0,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                                   clk,
  input  logic                                   we,
  input  logic [$clog2(DEPTH)-1:0]               waddr,
  input  logic [WIDTH-1:0]                       wdata,
  input  logic                                   init,
  input  logic [$clog2(DEPTH)-1:0]               init_addr,
  input  logic [RPORTS-1:0][$clog2(DEPTH)-1:0]   raddr,
  output logic [RPORTS-1:0][WIDTH-1:0]           rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we_d;
  logic [AW-1:0]    wa_d;
  logic [WIDTH-1:0] wd_d;
  always_comb begin
    we_d = we;
    wa_d = waddr;
    wd_d = wdata;
    if (HAS_INIT != 0 && init) begin
      we_d = 1'b1;
      wa_d = init_addr;
      wd_d = INITVAL;
    end
  end
  always_ff @(posedge clk)
    if (we_d) mem_q[wa_d] <= wd_d;
  always_comb
    for (int p = 0; p < RPORTS; p++) rdata[p] = mem_q[raddr[p]];
endmodule

// File: rtl/mwpram_init.sv
// mwpram_init: LVT multi-write-port RAM with self-clearing init walk, ready handshake and bypass
module mwpram_init
  import mwp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64,
  parameter int RPORTS = 2,
  parameter int WPORTS = 2,
  parameter int RLAT = 0,
  parameter int BYPASS = 1,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  output logic                                   ready,
  input  logic [RPORTS-1:0][$clog2(DEPTH)-1:0]   raddr,
  output logic [RPORTS-1:0][WIDTH-1:0]           rvalue,
  input  logic [WPORTS-1:0][$clog2(DEPTH)-1:0]   waddr,
  input  logic [WPORTS-1:0][WIDTH-1:0]           wvalue,
  input  logic [WPORTS-1:0]                      wena
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = selwidth(WPORTS);
  typedef logic [SW-1:0] sel_t;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          init_we;
  logic [WPORTS-1:0] wr_en;
  sel_t          sel_q [DEPTH];
  logic [WPORTS-1:0][RPORTS-1:0][WIDTH-1:0] bank_rd;
  logic [RPORTS-1:0][WIDTH-1:0] rv_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    init_we = state_q == INIT;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) state_d = RUN;
    end
    if (clr) begin
      state_d = INIT;
      cnt_d = '0;
    end
    ready_d = state_d == RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
    end
  assign ready = ready_q;
  // out-of-range write addresses never reach the banks or the select array
  always_comb
    for (int i = 0; i < WPORTS; i++)
      wr_en[i] = state_q == RUN && wena[i] && ({1'b0, waddr[i]} < DEPTH_L);
  // later ports overwrite earlier ones, so the highest index owns the entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < WPORTS; i++)
      if (wr_en[i]) sel_q[waddr[i]] <= sel_t'(i);
    if (init_we) sel_q[cnt_q] <= '0;
  end
  for (genvar g = 0; g < WPORTS; g++) begin : g_bank
    mwpram_bank #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .RPORTS(RPORTS),
      .HAS_INIT(g == 0 ? 1 : 0),
      .INITVAL(INITVAL)
    ) u_bank (
      .clk(clk),
      .we(wr_en[g]),
      .waddr(waddr[g]),
      .wdata(wvalue[g]),
      .init(init_we),
      .init_addr(cnt_q),
      .raddr(raddr),
      .rdata(bank_rd[g])
    );
  end
  always_comb
    for (int p = 0; p < RPORTS; p++) begin
      rv_d[p] = bank_rd[sel_q[raddr[p]]][p];
      if (BYPASS != 0)
        for (int i = 0; i < WPORTS; i++)
          if (wr_en[i] && waddr[i] == raddr[p]) rv_d[p] = wvalue[i];
      if (state_q == INIT || {1'b0, raddr[p]} >= DEPTH_L) rv_d[p] = INITVAL;
    end
  if (RLAT != 0) begin : g_rlat
    logic [RPORTS-1:0][WIDTH-1:0] rv_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) rv_q <= {RPORTS{INITVAL}};
      else rv_q <= rv_d;
    assign rvalue = rv_q;
  end else begin : g_rcomb
    assign rvalue = rv_d;
  end
endmodule

// File: tb/tb_mwpram_init.sv
// tb_mwpram_init: directed self-checking bench for three mwpram_init configurations
module tb_mwpram_init;
  logic clk = 1'b0;
  logic rst, clr;
  logic [1:0][2:0] raddr, waddr;
  logic [1:0][7:0] wvalue;
  logic [1:0]      wena;
  logic [1:0][7:0] rv0, rv1, rv2;
  logic            rdy0, rdy1, rdy2;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  // dut0: comb read + bypass, dut1: registered read no bypass, dut2: one write port, DEPTH 6
  mwpram_init #(.WIDTH(8), .DEPTH(8), .RPORTS(2), .WPORTS(2), .RLAT(0), .BYPASS(1), .INITVAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy0), .raddr(raddr), .rvalue(rv0),
    .waddr(waddr), .wvalue(wvalue), .wena(wena));
  mwpram_init #(.WIDTH(8), .DEPTH(8), .RPORTS(2), .WPORTS(2), .RLAT(1), .BYPASS(0), .INITVAL(8'h00)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy1), .raddr(raddr), .rvalue(rv1),
    .waddr(waddr), .wvalue(wvalue), .wena(wena));
  mwpram_init #(.WIDTH(8), .DEPTH(6), .RPORTS(2), .WPORTS(1), .RLAT(0), .BYPASS(1), .INITVAL(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .ready(rdy2), .raddr(raddr), .rvalue(rv2),
    .waddr(waddr[0]), .wvalue(wvalue[0]), .wena(wena[0]));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic walk(input logic wr);
    for (int i = 1; i <= 8; i++) begin
      wena = (wr && i <= 5) ? 2'b11 : 2'b00;
      waddr[0] = 3'd4; waddr[1] = 3'd2;
      wvalue[0] = 8'hDD; wvalue[1] = 8'hEE;
      raddr[0] = 3'd2; raddr[1] = 3'd4;
      #1;
      chk("walk_rdy0", {7'b0, rdy0}, 8'h00);
      chk("walk_rdy1", {7'b0, rdy1}, 8'h00);
      chk("walk_rdy2", {7'b0, rdy2}, (i >= 7) ? 8'h01 : 8'h00);
      chk("walk_rv0", rv0[0], 8'h00);
      chk("walk_rv2", rv2[0], 8'h5A);
      tick;
    end
    wena = 2'b00;
    #1;
    chk("walk_done_rdy0", {7'b0, rdy0}, 8'h01);
    chk("walk_done_rdy1", {7'b0, rdy1}, 8'h01);
    chk("walk_done_rdy2", {7'b0, rdy2}, 8'h01);
  endtask
  task automatic sweep;
    for (int a = 0; a < 8; a++) begin
      raddr[0] = 3'(a);
      raddr[1] = 3'(7 - a);
      #1;
      chk("sweep_rv0_p0", rv0[0], 8'h00);
      chk("sweep_rv0_p1", rv0[1], 8'h00);
      chk("sweep_rv2_p0", rv2[0], 8'h5A);
    end
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; wena = '0; raddr = '0; waddr = '0; wvalue = '0;
    #12;
    chk("rst_rdy0", {7'b0, rdy0}, 8'h00);
    chk("rst_rdy2", {7'b0, rdy2}, 8'h00);
    chk("rst_rv0", rv0[0], 8'h00);
    chk("rst_rv1", rv1[0], 8'h00);
    chk("rst_rv2", rv2[1], 8'h5A);
    tick;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk("init_rdy0", {7'b0, rdy0}, (i >= 8) ? 8'h01 : 8'h00);
      chk("init_rdy1", {7'b0, rdy1}, (i >= 8) ? 8'h01 : 8'h00);
      chk("init_rdy2", {7'b0, rdy2}, (i >= 6) ? 8'h01 : 8'h00);
    end
    sweep;
    tick;
    waddr[0] = 3'd3; wvalue[0] = 8'hAA; wena = 2'b01; raddr[0] = 3'd3; raddr[1] = 3'd2;
    #1;
    chk("aa_byp_rv0", rv0[0], 8'hAA);
    chk("aa_other_rv0", rv0[1], 8'h00);
    chk("aa_byp_rv2", rv2[0], 8'hAA);
    tick;
    waddr[1] = 3'd3; wvalue[1] = 8'hBB; wena = 2'b10;
    #1;
    chk("bb_byp_rv0", rv0[0], 8'hBB);
    chk("bb_old_rv1", rv1[0], 8'h00);
    chk("bb_keep_rv2", rv2[0], 8'hAA);
    tick;
    wena = 2'b00;
    #1;
    chk("bb_rv0", rv0[0], 8'hBB);
    chk("bb_addr2_rv0", rv0[1], 8'h00);
    chk("aa_rv1", rv1[0], 8'hAA);
    tick;
    #1;
    chk("bb_rv1", rv1[0], 8'hBB);
    chk("bb_addr2_rv1", rv1[1], 8'h00);
    waddr[0] = 3'd5; waddr[1] = 3'd5; wvalue[0] = 8'h11; wvalue[1] = 8'h22; wena = 2'b11; raddr[0] = 3'd5;
    #1;
    chk("same_byp_rv0", rv0[0], 8'h22);
    tick;
    wena = 2'b00;
    #1;
    chk("same_rv0", rv0[0], 8'h22);
    chk("same_old_rv1", rv1[0], 8'h00);
    chk("same_rv2", rv2[0], 8'h11);
    tick;
    #1;
    chk("same_rv1", rv1[0], 8'h22);
    waddr[0] = 3'd1; wvalue[0] = 8'h55; wena = 2'b01; raddr[0] = 3'd1;
    #1;
    chk("w55_byp_rv0", rv0[0], 8'h55);
    tick;
    wena = 2'b00;
    #1;
    chk("w55_old_rv1", rv1[0], 8'h00);
    tick;
    #1;
    chk("w55_rv1", rv1[0], 8'h55);
    chk("w55_rv2", rv2[0], 8'h55);
    waddr[0] = 3'd7; wvalue[0] = 8'h77; wena = 2'b01; raddr[0] = 3'd7; raddr[1] = 3'd7;
    #1;
    chk("oor_byp_rv0", rv0[0], 8'h77);
    chk("oor_byp_rv2", rv2[1], 8'h5A);
    tick;
    wena = 2'b00; raddr[1] = 3'd1;
    #1;
    chk("oor_rv0", rv0[0], 8'h77);
    chk("oor_rd_rv2", rv2[0], 8'h5A);
    chk("oor_noalias_rv2", rv2[1], 8'h55);
    clr = 1'b1;
    #1;
    chk("clr_pre_rdy0", {7'b0, rdy0}, 8'h01);
    tick;
    clr = 1'b0;
    walk(1'b1);
    sweep;
    tick;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (4) tick;
    wena = 2'b11; waddr[0] = 3'd4; waddr[1] = 3'd2; wvalue[0] = 8'hDD; wvalue[1] = 8'hEE;
    rst = 1'b1;
    #1;
    chk("midrst_rdy0", {7'b0, rdy0}, 8'h00);
    chk("midrst_rdy2", {7'b0, rdy2}, 8'h00);
    tick;
    rst = 1'b0;
    walk(1'b1);
    raddr[0] = 3'd2; raddr[1] = 3'd4;
    #1;
    chk("final_a2_rv0", rv0[0], 8'h00);
    chk("final_a4_rv0", rv0[1], 8'h00);
    chk("final_a4_rv2", rv2[1], 8'h5A);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
